// File: rtl/gf_pkg.sv
// Shared definitions for the binary-field divider: default field degree,
// the NIST B-163/K-163 reduction polynomial and the divider state type.
package gf_pkg;

    localparam int GF_NUM_BITS = 163;

    // F(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [163:0] POLY_163 = {1'b1, 155'd0, 8'b1100_1001};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } gf_div_state_t;

endpackage

// File: rtl/gf_div_param_chk.sv
// Run-time checks for gf_div_param: bounds the number of reduction steps
// and keeps the done/busy handshake consistent.
module gf_div_param_chk #(
    parameter int MAX_ITER = 652
) (
    input logic clk,
    input logic n_rst,
    input logic busy,
    input logic done
);

    logic [31:0] iter_cnt_q;

    // Count consecutive cycles spent iterating.
    always_ff @(posedge clk) begin
        if (!n_rst || !busy) begin
            iter_cnt_q <= 32'd0;
        end else begin
            iter_cnt_q <= iter_cnt_q + 32'd1;
        end
    end

    a_iter_bound: assert property (@(posedge clk) disable iff (!n_rst)
        (iter_cnt_q <= 32'(MAX_ITER)));

    a_done_not_busy: assert property (@(posedge clk) disable iff (!n_rst)
        (done |-> !busy));

endmodule

// File: rtl/gf_half_mod.sv
// Combinational division by x modulo F(x): z = x/x mod F.
// An odd operand has F added first so the shifted-out bit is always zero.
module gf_half_mod #(
    parameter int                NUM_BITS = 163,
    parameter logic [NUM_BITS:0] POLY     = {(NUM_BITS+1){1'b1}}
) (
    input  logic [NUM_BITS-1:0] x,
    output logic [NUM_BITS-1:0] z
);

    logic [NUM_BITS:0] sum_s;

    // Conditionally add F, then drop the (now zero) constant term.
    always_comb begin
        sum_s = {1'b0, x};
        if (x[0]) begin
            sum_s = {1'b0, x} ^ POLY;
        end else begin
            sum_s = {1'b0, x};
        end
        z = sum_s[NUM_BITS:1];
    end

endmodule

// File: rtl/gf_div_param.sv
// GF(2^m) divider Q = A/B mod F(x) using the binary extended Euclidean
// algorithm, one reduction step per clock.
// Optional feature macro: GF_DIV_INV_MODE_EN adds the inv port (Q = B^-1).
module gf_div_param
    import gf_pkg::*;
#(
    parameter int                NUM_BITS = GF_NUM_BITS,
    parameter logic [NUM_BITS:0] POLY     = POLY_163
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
`ifdef GF_DIV_INV_MODE_EN
    input  logic                inv,
`endif
    output logic [NUM_BITS-1:0] Q,
    output logic                done,
    output logic                busy,
    output logic                div_zero
);

    localparam logic [NUM_BITS-1:0] ONE_N = {{(NUM_BITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_BITS:0]   ONE_V = {{NUM_BITS{1'b0}}, 1'b1};
    localparam logic [NUM_BITS-1:0] ZERO_N = {NUM_BITS{1'b0}};

    gf_div_state_t       state_q;
    logic [NUM_BITS-1:0] u_q, x1_q, x2_q, q_q;
    logic [NUM_BITS:0]   v_q;
    logic                done_q, busy_q, div_zero_q;

    logic [NUM_BITS-1:0] x1_half_s, x2_half_s, x1_load_s;
    logic                u_one_s, v_one_s, u_gt_v_s, b_zero_s;

    gf_half_mod #(.NUM_BITS(NUM_BITS), .POLY(POLY)) u_half_x1 (
        .x(x1_q),
        .z(x1_half_s)
    );

    gf_half_mod #(.NUM_BITS(NUM_BITS), .POLY(POLY)) u_half_x2 (
        .x(x2_q),
        .z(x2_half_s)
    );

    // Step decode and the initial x1 value (A, or 1 when inverting).
    always_comb begin
        u_one_s  = (u_q == ONE_N);
        v_one_s  = (v_q == ONE_V);
        u_gt_v_s = ({1'b0, u_q} > v_q);
        b_zero_s = (B == ZERO_N);
        x1_load_s = A;
`ifdef GF_DIV_INV_MODE_EN
        if (inv) begin
            x1_load_s = ONE_N;
        end else begin
            x1_load_s = A;
        end
`endif
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            q_q        <= ZERO_N;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && b_zero_s) begin
                        state_q    <= DONE;
                        q_q        <= ZERO_N;
                        div_zero_q <= 1'b1;
                        done_q     <= 1'b1;
                    end else if (start) begin
                        state_q    <= ITER;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ITER: begin
                    if (u_one_s) begin
                        q_q     <= x1_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (v_one_s) begin
                        q_q     <= x2_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        state_q <= ITER;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Euclidean datapath: load on accepted start, one reduction per ITER cycle.
    // u > v is an integer compare; with equal degrees it still lowers a degree.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            u_q  <= ZERO_N;
            v_q  <= {(NUM_BITS+1){1'b0}};
            x1_q <= ZERO_N;
            x2_q <= ZERO_N;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !b_zero_s) begin
                        u_q  <= B;
                        v_q  <= POLY;
                        x1_q <= x1_load_s;
                        x2_q <= ZERO_N;
                    end
                end
                ITER: begin
                    if (u_one_s || v_one_s) begin
                        u_q <= u_q;
                    end else if (!u_q[0]) begin
                        u_q  <= u_q >> 1;
                        x1_q <= x1_half_s;
                    end else if (!v_q[0]) begin
                        v_q  <= v_q >> 1;
                        x2_q <= x2_half_s;
                    end else if (u_gt_v_s) begin
                        u_q  <= u_q ^ v_q[NUM_BITS-1:0];
                        x1_q <= x1_q ^ x2_q;
                    end else begin
                        v_q  <= v_q ^ {1'b0, u_q};
                        x2_q <= x2_q ^ x1_q;
                    end
                end
                default: begin
                    u_q <= u_q;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign div_zero = div_zero_q;

    gf_div_param_chk #(.MAX_ITER(4 * NUM_BITS)) u_chk (
        .clk  (clk),
        .n_rst(n_rst),
        .busy (busy_q),
        .done (done_q)
    );

endmodule

// File: tb/tb_gf_div_param.sv
// Self-checking bench for gf_div_param (163-bit default plus a 4-bit instance).
// Results are checked against polynomial multiplication mod F: Q*B == A.
module tb_gf_div_param;

    localparam logic [163:0] F163 = (164'd1 << 163) | 164'h0C9;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [162:0] a_i = '0, b_i = '0, q_o;
    logic         inv_i = 1'b0;
    logic         done_o, busy_o, dz_o;

    logic         start4 = 1'b0;
    logic [3:0]   a4 = '0, b4 = '0, q4;
    logic         inv4 = 1'b0;
    logic         done4, busy4, dz4;

    int n_assert = 0;
    int n_fail = 0;
    int lat;
    logic tmo;
    logic [162:0] sa, sb, exp_q;
    int cnt;

    always #5 clk = ~clk;

    gf_div_param dut (
        .clk(clk), .n_rst(n_rst), .start(start), .A(a_i), .B(b_i),
`ifdef GF_DIV_INV_MODE_EN
        .inv(inv_i),
`endif
        .Q(q_o), .done(done_o), .busy(busy_o), .div_zero(dz_o)
    );

    gf_div_param #(.NUM_BITS(4), .POLY(5'b10011)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .A(a4), .B(b4),
`ifdef GF_DIV_INV_MODE_EN
        .inv(inv4),
`endif
        .Q(q4), .done(done4), .busy(busy4), .div_zero(dz4)
    );

    // Polynomial product mod F(x), schoolbook shift-and-add.
    function automatic logic [162:0] gmul(input logic [162:0] x, input logic [162:0] y);
        logic [163:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r << 1;
            if (r[163]) r = r ^ F163;
            if (y[i]) r = r ^ {1'b0, x};
        end
        return r[162:0];
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[162:0];
    endfunction

    task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [162:0] a, input logic [162:0] b, input logic inv);
        @(negedge clk);
        a_i = a; b_i = b; inv_i = inv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done on the 163-bit instance; lat counts negedges since the start edge.
    task automatic wait_done();
        lat = 1;
        while (!done_o && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        tmo = !done_o;
    endtask

    task automatic run_div(input string tag, input logic [162:0] a, input logic [162:0] b,
                           input logic inv);
        launch(a, b, inv);
        wait_done();
        chk({tag, "_timeout"}, {163'd0, tmo}, 164'd0);
        chk({tag, "_model"}, {1'b0, gmul(q_o, b)}, inv ? 164'd1 : {1'b0, a});
        chk({tag, "_dz"}, {163'd0, dz_o}, 164'd0);
        chk({tag, "_iters"}, {163'd0, (lat - 1) <= 652}, 164'd1);
        exp_q = q_o;
        @(negedge clk);
        chk({tag, "_pulse"}, {162'd0, done_o, busy_o}, 164'd0);
        chk({tag, "_hold"}, {1'b0, q_o}, {1'b0, exp_q});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_q", {1'b0, q_o}, 164'd0);
        chk("rst_flags", {161'd0, done_o, busy_o, dz_o}, 164'd0);
        chk("rst4", {157'd0, q4, done4, busy4, dz4}, 164'd0);
        n_rst = 1'b1;

        // T1: 4-bit field, 1/x = x^3+1
        @(negedge clk);
        a4 = 4'b0001; b4 = 4'b0010; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 1;
        while (!done4 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("t1_q", {160'd0, q4}, 164'd9);
        chk("t1_dz", {163'd0, dz4}, 164'd0);
        chk("t1_lat", cnt, 164'd3);

        // T2: A == B, and a sparse dividend
        run_div("t2_eq", 163'h3C, 163'h3C, 1'b0);
        chk("t2_one", {1'b0, q_o}, 164'd1);
        sa = (163'd1 << 162) | (163'd1 << 161) | 163'hC9;
        run_div("t2_sparse", sa, 163'd60, 1'b0);

        // T3: divide by zero, then divide by one
        launch(163'd5, 163'd0, 1'b0);
        wait_done();
        chk("t3_z_lat", lat, 164'd1);
        chk("t3_z_dz", {163'd0, dz_o}, 164'd1);
        chk("t3_z_q", {1'b0, q_o}, 164'd0);
        @(negedge clk);
        chk("t3_z_pulse", {163'd0, done_o}, 164'd0);
        launch(163'd7, 163'd1, 1'b0);
        wait_done();
        chk("t3_one_lat", lat, 164'd2);
        chk("t3_one_q", {1'b0, q_o}, 164'd7);
        chk("t3_one_dz", {163'd0, dz_o}, 164'd0);
        @(negedge clk);

        // Random divisions
        for (int i = 0; i < 6; i++) begin
            sa = rand163();
            sb = rand163();
            if (sb == '0) sb = 163'd3;
            run_div("rnd", sa, sb, 1'b0);
        end

        // T4: start while busy is ignored
        sa = rand163(); sb = rand163() | 163'd1;
        launch(sa, sb, 1'b0);
        repeat (3) @(negedge clk);
        a_i = rand163(); b_i = rand163(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("t4_timeout", {163'd0, tmo}, 164'd0);
        chk("t4_first", {1'b0, gmul(q_o, sb)}, {1'b0, sa});
        cnt = 0;
        repeat (30) begin @(negedge clk); if (done_o || busy_o) cnt++; end
        chk("t4_noqueue", cnt, 164'd0);

        // T5: reset mid-operation
        launch(rand163(), rand163() | (163'd1 << 162), 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_busy_pre", {163'd0, busy_o}, 164'd1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("t5_q", {1'b0, q_o}, 164'd0);
        chk("t5_flags", {161'd0, done_o, busy_o, dz_o}, 164'd0);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (done_o) cnt++; end
        chk("t5_nodone", cnt, 164'd0);
        sa = rand163(); sb = rand163() | 163'd2;
        run_div("t5_fresh", sa, sb, 1'b0);

`ifdef GF_DIV_INV_MODE_EN
        // T6: inversion mode
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0010; inv4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 1;
        while (!done4 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("t6_q4", {160'd0, q4}, 164'd9);
        inv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb = rand163();
            if (sb == '0) sb = 163'd5;
            run_div("t6_inv", rand163(), sb, 1'b1);
        end
        run_div("t6_div", 163'd77, 163'd13, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
